// File: rtl/calc_result_display.sv
// Result display stage: captures a calculator result, converts the integer part
// to BCD with a sequential double-dabble, and scans it onto a 5-digit 7-seg display.
module calc_result_display #(
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] int_val,
    input  logic [3:0] frac1,
    input  logic [3:0] frac2,
    input  logic       show_frac,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [4:0] an
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {IDLE, CONV} state_t;
    state_t state, state_nxt;

    logic        accept, done;
    logic [2:0]  step;
    logic [19:0] sr, sr_adj, sr_nxt;
    logic [3:0]  f1_l, f2_l;
    logic        sf_l;
    logic [3:0]  hun, ten, uni, fr1, fr2;
    logic        sfr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (load) begin
                accept    = 1'b1;
                state_nxt = CONV;
            end
            CONV: if (step == 3'd7) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CONV);

    // one double-dabble step: add-3 on BCD nibbles >= 5, then shift
    always_comb begin
        sr_adj = sr;
        for (int k = 0; k < 3; k++)
            if (sr[8+4*k +: 4] >= 4'd5)
                sr_adj[8+4*k +: 4] = sr[8+4*k +: 4] + 4'd3;
        sr_nxt = sr_adj << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            step <= '0;
            f1_l <= '0;
            f2_l <= '0;
            sf_l <= 1'b0;
            hun  <= '0;
            ten  <= '0;
            uni  <= '0;
            fr1  <= '0;
            fr2  <= '0;
            sfr  <= 1'b0;
        end else begin
            if (accept) begin
                sr   <= {12'd0, int_val};
                step <= '0;
                f1_l <= frac1;
                f2_l <= frac2;
                sf_l <= show_frac;
            end else if (busy) begin
                sr   <= sr_nxt;
                step <= step + 3'd1;
            end
            if (done) begin
                hun <= sr_nxt[19:16];
                ten <= sr_nxt[15:12];
                uni <= sr_nxt[11:8];
                fr1 <= f1_l;
                fr2 <= f2_l;
                sfr <= sf_l;
            end
        end
    end

    logic [CW-1:0] cnt;
    logic [2:0]    idx, idx_nxt;
    logic          wrap;

    assign wrap    = (cnt == CW'(SCAN_DIV - 1));
    assign idx_nxt = wrap ? ((idx == 3'd4) ? 3'd0 : idx + 3'd1) : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            idx <= idx_nxt;
        end
    end

    // decode from the values that will be visible after this edge, so the
    // output registers switch on the same edge as the index or display update
    logic [3:0] e_h, e_t, e_u, e_f1, e_f2, dig;
    logic       e_sf, on, dot, lead_h, lead_t;
    logic [6:0] code;

    assign e_h  = done ? sr_nxt[19:16] : hun;
    assign e_t  = done ? sr_nxt[15:12] : ten;
    assign e_u  = done ? sr_nxt[11:8]  : uni;
    assign e_f1 = done ? f1_l : fr1;
    assign e_f2 = done ? f2_l : fr2;
    assign e_sf = done ? sf_l : sfr;

    always_comb begin
        dig    = e_u;
        on     = 1'b1;
        dot    = 1'b0;
        lead_h = (e_h != 4'd0);
        lead_t = lead_h || (e_t != 4'd0);
        if (!e_sf) begin
            case (idx_nxt)
                3'd0:    dig = e_u;
                3'd1:    begin dig = e_t; on = lead_t; end
                3'd2:    begin dig = e_h; on = lead_h; end
                default: on = 1'b0;
            endcase
        end else begin
            case (idx_nxt)
                3'd0:    dig = e_f2;
                3'd1:    dig = e_f1;
                3'd2:    begin dig = e_u; dot = 1'b1; end
                3'd3:    begin dig = e_t; on = lead_t; end
                3'd4:    begin dig = e_h; on = lead_h; end
                default: on = 1'b0;
            endcase
        end
        case (dig)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h40;
        endcase
    end

    logic [6:0] seg_q;
    logic       dp_q;
    logic [4:0] an_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else if (wrap || done) begin
            seg_q <= on ? code : 7'h00;
            dp_q  <= on & dot;
            an_q  <= on ? (5'd1 << idx_nxt) : 5'd0;
        end
    end

    assign seg = SEG_ACT_LOW ? ~seg_q : seg_q;
    assign dp  = SEG_ACT_LOW ? ~dp_q  : dp_q;
    assign an  = AN_ACT_LOW  ? ~an_q  : an_q;
endmodule

// File: tb/tb_calc_result_display.sv
// Randomized bench for calc_result_display: decimal reference model of what each
// digit slot must show, checked against the scanned outputs (active-high build).
module tb_calc_result_display;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] int_val = '0;
    logic [3:0] frac1 = '0, frac2 = '0;
    logic       show_frac = 1'b0;
    logic       busy, dp;
    logic [6:0] seg;
    logic [4:0] an;

    calc_result_display #(.SCAN_DIV(SD), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .int_val(int_val), .frac1(frac1),
        .frac2(frac2), .show_frac(show_frac), .busy(busy), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [6:0] cur_seg [5], nxt_seg [5];
    logic       cur_dp  [5], nxt_dp  [5];
    logic       cur_on  [5], nxt_on  [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic put(input int s, input int d, input bit vis, input bit dot);
        nxt_on[s]  = vis;
        nxt_seg[s] = vis ? seg_of(d) : 7'h00;
        nxt_dp[s]  = vis & dot;
    endtask

    // expected contents of every slot for a given result
    task automatic model(input int v, input int f1, input int f2, input bit sf);
        int h, t, u;
        h = v / 100; t = (v / 10) % 10; u = v % 10;
        for (int s = 0; s < 5; s++) put(s, 0, 1'b0, 1'b0);
        if (!sf) begin
            put(2, h, h != 0, 1'b0);
            put(1, t, (h != 0) || (t != 0), 1'b0);
            put(0, u, 1'b1, 1'b0);
        end else begin
            put(4, h, h != 0, 1'b0);
            put(3, t, (h != 0) || (t != 0), 1'b0);
            put(2, u, 1'b1, 1'b1);
            put(1, f1, 1'b1, 1'b0);
            put(0, f2, 1'b1, 1'b0);
        end
    endtask

    task automatic commit();
        for (int s = 0; s < 5; s++) begin
            cur_seg[s] = nxt_seg[s]; cur_dp[s] = nxt_dp[s]; cur_on[s] = nxt_on[s];
        end
    endtask

    // compare the currently lit slot against the old or the new expectation
    task automatic chk_slot(input string tag, input bit use_nxt, output int d);
        d = -1;
        if (an == 5'd0) begin
            chk({tag, "_dark"}, {25'd0, seg, dp}, 32'd0);
        end else begin
            chk({tag, "_onehot"}, 32'($onehot(an)), 32'd1);
            for (int s = 0; s < 5; s++) if (an[s]) d = s;
            chk($sformatf("%s_seg%0d", tag, d), 32'(seg), use_nxt ? 32'(nxt_seg[d]) : 32'(cur_seg[d]));
            chk($sformatf("%s_dp%0d", tag, d), 32'(dp), use_nxt ? 32'(nxt_dp[d]) : 32'(cur_dp[d]));
            chk($sformatf("%s_vis%0d", tag, d), 32'(use_nxt ? nxt_on[d] : cur_on[d]), 32'd1);
        end
    endtask

    task automatic scan_check(input string tag);
        bit seen [5];
        int d;
        for (int s = 0; s < 5; s++) seen[s] = 1'b0;
        for (int i = 0; i < 5 * SD + 2; i++) begin
            @(negedge clk);
            chk_slot(tag, 1'b0, d);
            if (d >= 0) seen[d] = 1'b1;
        end
        for (int s = 0; s < 5; s++)
            chk($sformatf("%s_seen%0d", tag, s), 32'(seen[s]), 32'(cur_on[s]));
    endtask

    // load a result; optionally try a second load at busy-loop iteration 'extra'
    task automatic do_load(input string tag, input int v, input int f1, input int f2,
                           input bit sf, input int extra);
        int n, d;
        @(negedge clk);
        int_val = 8'(v); frac1 = 4'(f1); frac2 = 4'(f2); show_frac = sf; load = 1'b1;
        model(v, f1, f2, sf);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0 || i == extra + 1) load = 1'b0;
            if (i == 0) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
            if (!busy) begin
                chk_slot({tag, "_upd"}, 1'b1, d);
                break;
            end
            n++;
            chk_slot({tag, "_hold"}, 1'b0, d);
            if (i == extra) begin
                int_val = 8'd9; frac1 = 4'd1; frac2 = 4'd1; show_frac = 1'b1; load = 1'b1;
            end
        end
        load = 1'b0;
        chk({tag, "_busy_len"}, 32'(n), 32'd8);
        commit();
        scan_check(tag);
    endtask

    initial begin
        int d;
        model(0, 0, 0, 1'b0);
        commit();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", {20'd0, an, seg}, 32'd0);
        chk("rst_dp", 32'(dp), 32'd0);
        rst_n = 1'b1;
        scan_check("idle0");

        do_load("t225", 225, 0, 0, 1'b0, -1);
        do_load("t3p50", 3, 5, 0, 1'b1, -1);
        do_load("t7ign", 7, 0, 0, 1'b0, 1);
        do_load("tendign", 42, 0, 0, 1'b0, 7);
        do_load("t100", 100, 0, 0, 1'b0, -1);
        do_load("tdash", 0, 15, 15, 1'b1, -1);
        do_load("t255", 255, 9, 9, 1'b1, -1);
        do_load("t10", 10, 0, 0, 1'b1, -1);

        for (int r = 0; r < 12; r++)
            do_load($sformatf("rnd%0d", r), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), -1);

        // reset in the middle of a conversion
        @(negedge clk);
        int_val = 8'd200; show_frac = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_out", {20'd0, an, seg}, 32'd0);
        chk("mid_dp", 32'(dp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model(0, 0, 0, 1'b0);
        commit();
        scan_check("mid_after");
        chk_slot("mid_final", 1'b0, d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
